// File: rtl/apb_slave_responder_if.sv
// APB4 completer-side bus bundle: requester drives select/address/data,
// completer returns ready, error and read data.
interface apb_slave_responder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic [2:0]              pprot;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pready;
  logic                    pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_slave_responder.sv
// APB4 completer backed by a NUM_REGS-word register file with byte strobes,
// programmable wait states and pslverr on out-of-range or misaligned access.
module apb_slave_responder #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                 pclk,
  input  logic                 preset,
  apb_slave_responder_if.slave apb,
  input  logic [3:0]           wait_cfg,
  output logic                 xfer_done
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int ALIGN = $clog2(BYTES);
  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] SPAN      = ADDR_WIDTH'(NUM_REGS * BYTES);
  localparam logic [ADDR_WIDTH-1:0] LANE_MASK = ADDR_WIDTH'(BYTES - 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                state;
  logic [3:0]            cnt;
  logic                  pwrite_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic [BYTES-1:0]      pstrb_q;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic [ADDR_WIDTH-1:0] dec_addr;
  logic                  dec_write;
  logic                  dec_err;
  logic [IDX_W-1:0]      dec_idx;
  logic [DATA_WIDTH-1:0] rdata_nxt;
  logic                  unused_prot;

  function automatic logic addr_err(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return (a < BASE_ADDR) || (off >= SPAN) || ((a & LANE_MASK) != '0);
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> ALIGN);
  endfunction

  assign unused_prot = ^apb.pprot;

  // Zero-wait transfers resolve in the setup cycle, before the latches hold the address.
  always_comb begin
    dec_addr  = (state == IDLE) ? apb.paddr  : paddr_q;
    dec_write = (state == IDLE) ? apb.pwrite : pwrite_q;
    dec_err   = addr_err(dec_addr);
    dec_idx   = addr_idx(dec_addr);
    rdata_nxt = (!dec_write && !dec_err) ? regs[dec_idx] : '0;
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state       <= IDLE;
      cnt         <= '0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      apb.prdata  <= '0;
      apb.pready  <= 1'b0;
      apb.pslverr <= 1'b0;
      xfer_done   <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      xfer_done <= 1'b0;
      case (state)
        IDLE: begin
          if (apb.psel && !apb.penable) begin
            pwrite_q <= apb.pwrite;
            paddr_q  <= apb.paddr;
            pwdata_q <= apb.pwdata;
            pstrb_q  <= apb.pstrb;
            cnt      <= wait_cfg;
            state    <= ACCESS;
            if (wait_cfg == 4'd0) begin
              apb.pready  <= 1'b1;
              apb.pslverr <= dec_err;
              apb.prdata  <= rdata_nxt;
            end
          end
        end
        ACCESS: begin
          if (apb.pready) begin
            if (pwrite_q && !apb.pslverr) begin
              for (int b = 0; b < BYTES; b++)
                if (pstrb_q[b]) regs[dec_idx][8*b +: 8] <= pwdata_q[8*b +: 8];
            end
            apb.pready  <= 1'b0;
            apb.pslverr <= 1'b0;
            apb.prdata  <= '0;
            xfer_done   <= 1'b1;
            state       <= IDLE;
          end else if (!apb.psel) begin
            state <= IDLE;
          end else if (apb.penable) begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
              apb.pready  <= 1'b1;
              apb.pslverr <= dec_err;
              apb.prdata  <= rdata_nxt;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_slave_responder.sv
// Randomized scoreboard bench for apb_slave_responder: a driver issues APB
// transfers and queues expected responses, a monitor checks each completion.
module tb_apb_slave_responder;

  localparam int          AW   = 32;
  localparam int          DW   = 32;
  localparam int          NR   = 16;
  localparam logic [31:0] BASE = 32'h0000_1000;

  typedef struct {
    logic        err;
    logic        is_read;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  logic       pclk = 1'b0;
  logic       preset = 1'b1;
  logic [3:0] wait_cfg = 4'd0;
  logic       xfer_done;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  logic        prev_rdy = 1'b0;
  logic [31:0] mem [NR];
  exp_t        sb [$];
  exp_t        mon_e;

  apb_slave_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb ();

  apb_slave_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .BASE_ADDR(BASE)
  ) dut (
    .pclk(pclk), .preset(preset), .apb(apb), .wait_cfg(wait_cfg), .xfer_done(xfer_done)
  );

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  // Reference: APB register file semantics with plain address arithmetic.
  function automatic exp_t model(input logic wr, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [3:0] strb,
                                 input logic [3:0] n);
    exp_t   e;
    longint off;
    int     idx;
    off       = longint'(addr) - longint'(BASE);
    e.err     = (off < 0) || (off >= NR * 4) || (addr % 4 != 0);
    e.is_read = !wr;
    e.rdata   = 32'h0;
    e.cyc     = cyc + 1 + int'(n);
    if (!e.err) begin
      idx = int'(off / 4);
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (strb[b]) mem[idx][8*b +: 8] = data[8*b +: 8];
      end else begin
        e.rdata = mem[idx];
      end
    end
    return e;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NR; i++) mem[i] = 32'h0;
  endtask

  // Called at a negedge; returns at the negedge following the completion edge
  // (plus one idle cycle unless back-to-back).
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input logic [3:0] n, input bit b2b);
    int t;
    sb.push_back(model(wr, addr, data, strb, n));
    apb.psel    = 1'b1;
    apb.penable = 1'b0;
    apb.pwrite  = wr;
    apb.paddr   = addr;
    apb.pwdata  = data;
    apb.pstrb   = strb;
    apb.pprot   = 3'($urandom);
    wait_cfg    = n;
    @(negedge pclk);
    apb.penable = 1'b1;
    apb.pwdata  = $urandom;
    apb.pstrb   = 4'($urandom);
    apb.paddr   = $urandom;
    apb.pwrite  = 1'($urandom);
    wait_cfg    = 4'($urandom);
    t = 0;
    while (apb.pready !== 1'b1 && t < 40) begin
      @(negedge pclk);
      t++;
    end
    if (t >= 40) begin
      total++;
      bad++;
      $display("FAIL pready_timeout addr=%h: got no pready want pready within %0d cycles", addr, n + 1);
    end
    @(negedge pclk);
    if (!b2b) begin
      apb.psel    = 1'b0;
      apb.penable = 1'b0;
      @(negedge pclk);
    end
  endtask

  always @(negedge pclk) begin
    if (apb.pready === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pready at cycle %0d: got pready=1 want no pending transfer", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("pslverr", {31'b0, apb.pslverr}, {31'b0, mon_e.err});
        if (mon_e.is_read) chk("prdata", apb.prdata, mon_e.rdata);
        chk("pready_cycle", cyc, mon_e.cyc);
      end
    end
    if (xfer_done === 1'b1) done_cnt++;
    if (xfer_done === 1'b1 || prev_rdy) chk("xfer_done", {31'b0, xfer_done}, {31'b0, prev_rdy});
    prev_rdy = (apb.pready === 1'b1);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] addr;
    logic [3:0]  n;
    int          d0;
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
    apb.paddr = '0; apb.pwdata = '0; apb.pstrb = '0; apb.pprot = '0;
    clear_model();
    repeat (3) @(negedge pclk);
    chk("reset_pready",    {31'b0, apb.pready},  32'h0);
    chk("reset_pslverr",   {31'b0, apb.pslverr}, 32'h0);
    chk("reset_prdata",    apb.prdata,           32'h0);
    chk("reset_xfer_done", {31'b0, xfer_done},   32'h0);
    preset = 1'b0;
    @(negedge pclk);

    for (int i = 0; i < NR; i++) xfer(1'b0, BASE + 32'(4 * i), 32'h0, 4'h0, 4'd0, 1'b0);

    xfer(1'b1, BASE + 32'h8, 32'hDEADBEEF, 4'b1111, 4'd0, 1'b0);
    xfer(1'b1, BASE + 32'h8, 32'h000000AA, 4'b0001, 4'd0, 1'b0);
    xfer(1'b0, BASE + 32'h8, 32'h0, 4'h0, 4'd0, 1'b0);

    xfer(1'b1, BASE + 32'hC, 32'h0BADF00D, 4'b1111, 4'd3, 1'b0);
    xfer(1'b0, BASE + 32'hC, 32'h0, 4'h0, 4'd1, 1'b0);

    // Abandoned write: the register must keep its old contents.
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1;
    apb.paddr = BASE + 32'h8; apb.pwdata = 32'h12345678; apb.pstrb = 4'hF; wait_cfg = 4'd3;
    @(negedge pclk);
    apb.penable = 1'b1;
    @(negedge pclk);
    apb.psel = 1'b0; apb.penable = 1'b0;
    repeat (2) @(negedge pclk);
    xfer(1'b0, BASE + 32'h8, 32'h0, 4'h0, 4'd0, 1'b0);

    xfer(1'b0, BASE + 32'(NR * 4), 32'h0, 4'h0, 4'd0, 1'b0);
    xfer(1'b1, BASE + 32'h2, 32'hFFFFFFFF, 4'hF, 4'd2, 1'b0);
    xfer(1'b0, BASE - 32'h4, 32'h0, 4'h0, 4'd1, 1'b0);
    xfer(1'b0, BASE, 32'h0, 4'h0, 4'd0, 1'b0);

    d0 = done_cnt;
    xfer(1'b1, BASE + 32'h10, 32'hCAFEF00D, 4'hF, 4'd2, 1'b1);
    xfer(1'b0, BASE + 32'h10, 32'h0, 4'h0, 4'd0, 1'b0);
    chk("b2b_done_pulses", 32'(done_cnt - d0), 32'd2);

    for (int k = 0; k < 150; k++) begin
      case ($urandom_range(0, 9))
        0:       addr = BASE + 32'($urandom_range(0, 80));
        1:       addr = BASE - 32'(4 * $urandom_range(1, 4));
        default: addr = BASE + 32'(4 * $urandom_range(0, NR - 1));
      endcase
      n = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      xfer(1'($urandom), addr, $urandom, 4'($urandom), n, 1'($urandom));
    end
    apb.psel = 1'b0; apb.penable = 1'b0;
    @(negedge pclk);

    // Reset during the second wait cycle of a 5-wait write.
    xfer(1'b1, BASE + 32'h14, 32'h5A5A1234, 4'hF, 4'd0, 1'b0);
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1;
    apb.paddr = BASE + 32'h14; apb.pwdata = 32'hFFFF0000; apb.pstrb = 4'hF; wait_cfg = 4'd5;
    @(negedge pclk);
    apb.penable = 1'b1;
    @(negedge pclk);
    preset = 1'b1;
    @(negedge pclk);
    chk("rst_mid_pready",    {31'b0, apb.pready},  32'h0);
    chk("rst_mid_pslverr",   {31'b0, apb.pslverr}, 32'h0);
    chk("rst_mid_prdata",    apb.prdata,           32'h0);
    chk("rst_mid_xfer_done", {31'b0, xfer_done},   32'h0);
    preset = 1'b0;
    apb.psel = 1'b0; apb.penable = 1'b0;
    clear_model();
    @(negedge pclk);
    xfer(1'b0, BASE + 32'h14, 32'h0, 4'h0, 4'd0, 1'b0);
    xfer(1'b1, BASE + 32'h14, 32'h01020304, 4'b0110, 4'd1, 1'b0);
    xfer(1'b0, BASE + 32'h14, 32'h0, 4'h0, 4'd2, 1'b0);

    repeat (2) @(negedge pclk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
